// File: rtl/lru_pkg.sv
// lru_pkg: shared types and tree-PLRU helpers for the 4-way PLRU controller.
//   plru_bits_t : 3 PLRU bits per set. Bit 0 is the root and picks the pair
//                 (0 = left pair, 1 = right pair). Bit 1 picks within the
//                 left pair and bit 2 picks within the right pair.
//   way_t       : way number 0..3.
//   lru_state_t : states of the flush sequencer.
package lru_pkg;

    typedef logic [2:0] plru_bits_t;
    typedef logic [1:0] way_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } lru_state_t;

    // Follow the tree pointers down to the least-recently-used way.
    function automatic way_t plru_victim(input plru_bits_t bits);
        way_t v;
        if (bits[0] == 1'b0) begin
            v = bits[1] ? 2'd1 : 2'd0;
        end else begin
            v = bits[2] ? 2'd3 : 2'd2;
        end
        return v;
    endfunction

    // Point the tree away from the accessed way. Bits on the other branch are kept.
    function automatic plru_bits_t plru_touch(input plru_bits_t bits, input way_t way);
        plru_bits_t n;
        n = bits;
        case (way)
            2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
            2'd3:    begin n[0] = 1'b0; n[2] = 1'b0; end
            default: n = bits;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lru_fwd.sv
// lru_fwd: two-slot write-forwarding shift register for the PLRU array.
// The array shows a write only to reads issued two or more cycles later. This
// block therefore remembers the last two writes and overrides stale read data.
//   clk, rst_n : clock and asynchronous active-low reset
//   wr_en      : a write is issued on array port 1 this cycle
//   wr_set     : address of that write
//   wr_bits    : data of that write
//   rd_set     : set currently held in stage 2
//   arr_bits   : array read data for rd_set
//   cur_bits   : freshest PLRU bits for rd_set
module lru_fwd #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_set,
    input  logic [WIDTH-1:0]   wr_bits,
    input  logic [S_INDEX-1:0] rd_set,
    input  logic [WIDTH-1:0]   arr_bits,
    output logic [WIDTH-1:0]   cur_bits
);

    logic               fw0_valid_r, fw1_valid_r;
    logic [S_INDEX-1:0] fw0_set_r,   fw1_set_r;
    logic [WIDTH-1:0]   fw0_bits_r,  fw1_bits_r;

    // Shift the write history every cycle. Slots keep ageing during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw0_valid_r <= 1'b0;
            fw0_set_r   <= {S_INDEX{1'b0}};
            fw0_bits_r  <= {WIDTH{1'b0}};
            fw1_valid_r <= 1'b0;
            fw1_set_r   <= {S_INDEX{1'b0}};
            fw1_bits_r  <= {WIDTH{1'b0}};
        end else begin
            fw1_valid_r <= fw0_valid_r;
            fw1_set_r   <= fw0_set_r;
            fw1_bits_r  <= fw0_bits_r;
            fw0_valid_r <= wr_en;
            fw0_set_r   <= wr_set;
            fw0_bits_r  <= wr_bits;
        end
    end

    // The youngest matching write wins. Without a match, use the array data.
    always_comb begin
        cur_bits = arr_bits;
        if (fw0_valid_r && (fw0_set_r == rd_set)) begin
            cur_bits = fw0_bits_r;
        end else if (fw1_valid_r && (fw1_set_r == rd_set)) begin
            cur_bits = fw1_bits_r;
        end else begin
            cur_bits = arr_bits;
        end
    end

endmodule

// File: rtl/lru_ctrl.sv
// lru_ctrl: sequencer for the dual-port tree-PLRU state array of a pipelined
// 4-way cache.
//   Stage 1 reads the set on array port 0.
//   Stage 2 computes the victim and the updated bits, then writes them on port 1.
//   A flush sweep zeroes every set and then pulses flush_done.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   lookup_valid/lookup_set        stage-1 request; lookup_ready = accepted
//   stall                          pipeline stall; freezes stage 2
//   resp_valid/resp_hit/resp_way   stage-2 tag result
//   victim_way                     replacement way for the stage-2 set
//                                  (combinational)
//   flush_req/flush_done           flush request / one-cycle completion pulse
//   arr_csb0/web0/addr0/dout0      array read port
//   arr_csb1/web1/addr1/din1       array write port
module lru_ctrl
    import lru_pkg::*;
#(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4,
    parameter int WIDTH   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lookup_valid,
    input  logic [S_INDEX-1:0]       lookup_set,
    output logic                     lookup_ready,
    input  logic                     stall,
    input  logic                     resp_valid,
    input  logic                     resp_hit,
    input  logic [$clog2(WAYS)-1:0]  resp_way,
    output logic [$clog2(WAYS)-1:0]  victim_way,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     arr_csb0,
    output logic                     arr_web0,
    output logic [S_INDEX-1:0]       arr_addr0,
    input  logic [WIDTH-1:0]         arr_dout0,
    output logic                     arr_csb1,
    output logic                     arr_web1,
    output logic [S_INDEX-1:0]       arr_addr1,
    output logic [WIDTH-1:0]         arr_din1
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    lru_state_t         state_r, state_nxt_s;
    logic [S_INDEX-1:0] flush_cnt_r, flush_cnt_nxt_s;
    logic               drain_cnt_r, drain_cnt_nxt_s;
    logic               flush_done_r, flush_done_nxt_s;
    logic               ready_en_r;
    logic               s2_valid_r;
    logic [S_INDEX-1:0] s2_set_r;

    logic               flush_accept_s, ready_s, lookup_fire_s, update_fire_s;
    logic               wr_en_s;
    logic [S_INDEX-1:0] wr_addr_s;
    logic [WIDTH-1:0]   wr_data_s;
    plru_bits_t         cur_bits_s, next_bits_s;
    way_t               victim_s, access_way_s;

    // A flush starts only when stage 2 is empty. Lookups are refused from the
    // accepting cycle onward.
    assign flush_accept_s = (state_r == IDLE) && flush_req && !s2_valid_r;
    // ready_en_r holds lookup_ready low while reset is asserted.
    assign ready_s        = ready_en_r && (state_r == IDLE) && !flush_accept_s;
    assign lookup_fire_s  = lookup_valid && ready_s && !stall;
    assign update_fire_s  = s2_valid_r && resp_valid && !stall;

    assign lookup_ready = ready_s;
    assign flush_done   = flush_done_r;

    lru_fwd #(
        .S_INDEX (S_INDEX),
        .WIDTH   (WIDTH)
    ) u_fwd (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_s),
        .wr_set   (wr_addr_s),
        .wr_bits  (wr_data_s),
        .rd_set   (s2_set_r),
        .arr_bits (arr_dout0),
        .cur_bits (cur_bits_s)
    );

    assign victim_s     = plru_victim(cur_bits_s);
    assign access_way_s = resp_hit ? resp_way : victim_s;
    assign next_bits_s  = plru_touch(cur_bits_s, access_way_s);
    assign victim_way   = victim_s;

    // Stage-2 pipeline register. Every register holds while stall is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_set_r   <= {S_INDEX{1'b0}};
        end else if (!stall) begin
            s2_valid_r <= lookup_fire_s;
            if (lookup_fire_s) begin
                s2_set_r <= lookup_set;
            end
        end
    end

    // Sequencer state, sweep counters, done pulse and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            flush_cnt_r  <= {S_INDEX{1'b0}};
            drain_cnt_r  <= 1'b0;
            flush_done_r <= 1'b0;
            ready_en_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            flush_cnt_r  <= flush_cnt_nxt_s;
            drain_cnt_r  <= drain_cnt_nxt_s;
            flush_done_r <= flush_done_nxt_s;
            ready_en_r   <= 1'b1;
        end
    end

    // Next-state logic: the sweep writes one set per cycle, then DRAIN waits
    // two cycles before the done pulse.
    always_comb begin
        state_nxt_s      = state_r;
        flush_cnt_nxt_s  = flush_cnt_r;
        drain_cnt_nxt_s  = drain_cnt_r;
        flush_done_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush_accept_s) begin
                    state_nxt_s     = FLUSH;
                    flush_cnt_nxt_s = {S_INDEX{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == S_INDEX'(NUM_SETS - 1)) begin
                    state_nxt_s     = DRAIN;
                    flush_cnt_nxt_s = {S_INDEX{1'b0}};
                    drain_cnt_nxt_s = 1'b0;
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r + S_INDEX'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_r) begin
                    state_nxt_s      = IDLE;
                    drain_cnt_nxt_s  = 1'b0;
                    flush_done_nxt_s = 1'b1;
                end else begin
                    drain_cnt_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Write-port source: the flush sweep owns port 1. Outside a flush, stage-2
    // updates use it. Stage 2 is always empty during a sweep.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {S_INDEX{1'b0}};
        wr_data_s = {WIDTH{1'b0}};
        if (state_r == FLUSH) begin
            wr_en_s   = 1'b1;
            wr_addr_s = flush_cnt_r;
            wr_data_s = {WIDTH{1'b0}};
        end else if (update_fire_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = s2_set_r;
            wr_data_s = next_bits_s;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Array port drive. Idle ports are deselected and their address/data are zero.
    always_comb begin
        arr_csb0  = 1'b1;
        arr_web0  = 1'b1;
        arr_addr0 = {S_INDEX{1'b0}};
        if (lookup_fire_s) begin
            arr_csb0  = 1'b0;
            arr_addr0 = lookup_set;
        end else begin
            arr_csb0 = 1'b1;
        end
        arr_csb1 = ~wr_en_s;
        arr_web1 = ~wr_en_s;
        arr_addr1 = wr_addr_s;
        arr_din1  = wr_data_s;
    end

endmodule
